spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- SPI mode-0 master controller (CPOL=0, CPHA=0, MSB first) for single-word transfers.
- Generates SCLK internally from clk_in using a half-period tick counter; no derived clock domain.
- Sequences chip-select, shifting and sampling, and presents a start/busy/done handshake to the host logic.
- Sits between the system-side register/command logic and the external SPI pins.

Parameters:
- CLK_IN_FREQ, 100000000, input clock frequency in Hz.
- SCLK_FREQ, 200000, SPI clock frequency in Hz.
- DATA_WIDTH, 8, bits per transfer.
- Derived H = CLK_IN_FREQ/(2*SCLK_FREQ): clk_in cycles per SCLK half-period. Elaboration error if H < 2.

Ports:
- clk_in  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  transfer request; sampled only in IDLE.
- tx_data  input  DATA_WIDTH  word to send; captured on the accepting edge.
- rx_data  output  DATA_WIDTH  last received word.
- busy  output  1  high while a transfer (including deselect time) is in progress.
- done  output  1  one-cycle completion pulse.
- sclk  output  1  SPI clock.
- mosi  output  1  master out.
- miso  input  1  master in.
- cs_n  output  1  active-low chip select.

Behaviour:
- Reset (async, immediate, including mid-transfer): sclk=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=0, FSM=IDLE, tick counter=0, bit counter=0.
- Tick counter: width max(1,$clog2(H)); counts 0..H-1 and wraps, asserting tick at H-1. It is held at 0 in IDLE and restarts at 0 on entry to SETUP.
- IDLE:
  - On a clk_in edge with start=1: latch tx_data into the shift register; next cycle cs_n=0, busy=1, mosi=tx_data[DATA_WIDTH-1]; go to SETUP.
  - start=0: remain in IDLE with all outputs stable.
- SETUP: hold for H cycles with sclk=0 (MOSI setup time); on tick go to TRANSFER.
- TRANSFER: sclk toggles on every tick, for 2*DATA_WIDTH half-periods.
  - Rising edge (sclk 0->1): shift miso into the rx shift register LSB on that same clk_in edge. miso is not synchronized; it is stable by construction because the slave changes it on falling edges.
  - Falling edge (sclk 1->0): shift mosi to the next bit, unless it is the last falling edge.
  - After the DATA_WIDTH-th falling edge go to HOLD; sclk stays 0.
- HOLD: H cycles with sclk=0 and cs_n=0; on tick go to DONE.
- DONE:
  - First cycle: cs_n=1, rx_data updated with the received word, done=1 for exactly one cycle.
  - The state lasts H cycles (minimum cs_n deselect time); busy stays 1 throughout.
  - At the end, busy=0 and the FSM returns to IDLE.
- Timing (accepting edge = cycle 0):
  - cs_n falls at cycle 1.
  - First sclk rise at cycle 1+H.
  - done asserted at cycle 1+(2*DATA_WIDTH+2)*H.
  - busy falls at cycle 1+(2*DATA_WIDTH+3)*H.
- Handshake rules:
  - start while busy is ignored; no queueing.
  - start held high continuously yields back-to-back transfers, with cs_n high for exactly H cycles between them.
  - tx_data changes after acceptance have no effect on the current transfer.
- rx_data holds its value between transfers and is unaffected by an aborted transfer (reset clears it to 0).
- mosi: after the last bit, mosi holds that bit until the next acceptance.
- Bit counter width: $clog2(DATA_WIDTH+1).

Test Plan:
- Timing: CLK_IN_FREQ=1000, SCLK_FREQ=100 (H=5), DATA_WIDTH=8; pulse start with tx_data=0xA5 and miso looped to mosi -> mosi bit sequence 1,0,1,0,0,1,0,1 valid at each sclk rise; rx_data=0xA5; done pulse at cycle 91; busy low at cycle 96; exactly 8 sclk rising edges.
- Fixed miso: miso tied to 1, tx_data=0x00 -> rx_data=0xFF; mosi=0 throughout; cs_n low only from cycle 1 to cycle 90.
- Start while busy: start pulse with tx_data=0x3C at cycle 40 of an active 0x5A transfer -> ignored; only 0x5A shifted out; exactly one done pulse.
- Back-to-back: start held high, tx_data 0x81 then 0x7E -> two transfers with cs_n high for exactly 5 cycles between them; two done pulses 95 cycles apart.
- Reset mid-operation: rst asserted at cycle 50 of a transfer -> sclk=0, cs_n=1, busy=0, done=0, rx_data=0 immediately (asynchronously); no done pulse; a new start after reset release yields a normal transfer.
- Elaboration guard: H=1 configuration (CLK_IN_FREQ=200, SCLK_FREQ=100) -> elaboration error.

Source files
------------

// File: rtl/spi_master_ctrl_if.sv
// Host-side handshake and SPI pin bundle for spi_master_ctrl.
// master = the controller itself, slave = the host/pin environment around it.
interface spi_master_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  busy;
  logic                  done;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic                  cs_n;

  modport master (
    input  start, tx_data, miso,
    output rx_data, busy, done, sclk, mosi, cs_n
  );

  modport slave (
    output start, tx_data, miso,
    input  rx_data, busy, done, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) single-word master.
// SCLK is a registered toggle driven by a half-period tick counter on clk_in.
module spi_master_ctrl #(
  parameter int unsigned CLK_IN_FREQ = 100000000,
  parameter int unsigned SCLK_FREQ   = 200000,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  spi_master_ctrl_if.master bus
);
  localparam int unsigned H     = CLK_IN_FREQ / (2 * SCLK_FREQ);
  localparam int unsigned CNT_W = ($clog2(H) < 1) ? 1 : $clog2(H);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(H - 1);
  localparam logic [BIT_W-1:0] BITS_ALL  = BIT_W'(DATA_WIDTH);

  if (H < 2) begin : g_h_guard
    $error("spi_master_ctrl: CLK_IN_FREQ/(2*SCLK_FREQ) must be at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_TRANSFER,
    ST_HOLD,
    ST_DONE
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic [DATA_WIDTH-1:0] rx_shift_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  sclk_q;
  logic                  cs_n_q;
  logic                  busy_q;
  logic                  done_q;

  logic tick_c;
  logic accept_c;

  assign tick_c = (cnt_q == TICK_LAST);
  // A start seen on the last DONE cycle is taken at once so back-to-back
  // transfers keep cs_n high for exactly one half-period.
  assign accept_c = bus.start &&
                    ((state_q == ST_IDLE) || ((state_q == ST_DONE) && tick_c));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (state_q == ST_IDLE || tick_c) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      unique case (state_q)
        ST_IDLE: ;
        ST_SETUP: begin
          if (tick_c) begin
            state_q    <= ST_TRANSFER;
            sclk_q     <= 1'b1;
            rx_shift_q <= (rx_shift_q << 1) | DATA_WIDTH'(bus.miso);
            bit_cnt_q  <= bit_cnt_q + BIT_W'(1);
          end
        end
        ST_TRANSFER: begin
          if (tick_c) begin
            if (sclk_q) begin
              sclk_q <= 1'b0;
              if (bit_cnt_q != BITS_ALL) begin
                tx_shift_q <= tx_shift_q << 1;
              end
            end else if (bit_cnt_q == BITS_ALL) begin
              state_q <= ST_HOLD;
            end else begin
              // miso is stable here: the slave only moves it on falling edges
              sclk_q     <= 1'b1;
              rx_shift_q <= (rx_shift_q << 1) | DATA_WIDTH'(bus.miso);
              bit_cnt_q  <= bit_cnt_q + BIT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (tick_c) begin
            state_q   <= ST_DONE;
            cs_n_q    <= 1'b1;
            rx_data_q <= rx_shift_q;
            done_q    <= 1'b1;
          end
        end
        ST_DONE: begin
          if (tick_c) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (accept_c) begin
        state_q    <= ST_SETUP;
        tx_shift_q <= bus.tx_data;
        cs_n_q     <= 1'b0;
        busy_q     <= 1'b1;
        bit_cnt_q  <= '0;
        cnt_q      <= '0;
      end
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.mosi    = tx_shift_q[DATA_WIDTH-1];
  assign bus.cs_n    = cs_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with H=5, 8-bit words; cycle 1 is the
// first cycle after the accepting edge.
module tb_spi_master_ctrl;
  logic clk_in = 1'b0;
  logic rst;
  logic loop_en;
  logic miso_val;

  int checks = 0;
  int errors = 0;

  spi_master_ctrl_if #(.DATA_WIDTH(8)) bus ();

  spi_master_ctrl #(
    .CLK_IN_FREQ(1000),
    .SCLK_FREQ  (100),
    .DATA_WIDTH (8)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  assign bus.miso = loop_en ? bus.mosi : miso_val;

  // observation record for the current transfer window
  int         cyc;
  int         rises;
  int         first_rise;
  int         done_cnt;
  int         done_at0;
  int         done_at1;
  int         cs_first;
  int         cs_last;
  int         busy_fall;
  int         mosi_ones;
  int         hi_run;
  int         gap;
  logic [7:0] mosi_seq;
  logic       sclk_prev;
  logic       busy_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    cyc = 0; rises = 0; first_rise = 0; done_cnt = 0; done_at0 = 0; done_at1 = 0;
    cs_first = 0; cs_last = 0; busy_fall = 0; mosi_ones = 0; hi_run = 0; gap = 0;
    mosi_seq = 8'h00;
    sclk_prev = bus.sclk;
    busy_prev = bus.busy;
  endtask

  task automatic step();
    @(negedge clk_in);
    cyc++;
    if (bus.sclk && !sclk_prev) begin
      rises++;
      mosi_seq = {mosi_seq[6:0], bus.mosi};
      if (first_rise == 0) first_rise = cyc;
    end
    sclk_prev = bus.sclk;
    if (bus.done) begin
      if (done_cnt == 0) done_at0 = cyc;
      else if (done_cnt == 1) done_at1 = cyc;
      done_cnt++;
    end
    if (!bus.cs_n) begin
      if (cs_first == 0) cs_first = cyc;
      cs_last = cyc;
      if (hi_run > 0 && gap == 0) gap = hi_run;
      hi_run = 0;
    end else if (cs_first != 0) begin
      hi_run++;
    end
    if (bus.mosi) mosi_ones++;
    if (busy_prev && !bus.busy && busy_fall == 0) busy_fall = cyc;
    busy_prev = bus.busy;
  endtask

  // one-cycle start pulse; tx_data is scrambled after acceptance
  task automatic pulse_xfer(input logic [7:0] tx, input int ncyc);
    clear_obs();
    bus.start   = 1'b1;
    bus.tx_data = tx;
    step();
    bus.start   = 1'b0;
    bus.tx_data = ~tx;
    repeat (ncyc - 1) step();
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.tx_data = 8'h00; loop_en = 1'b1; miso_val = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_sclk", bus.sclk, 1'b0);
    chk("rst_cs_n", bus.cs_n, 1'b1);
    chk("rst_mosi", bus.mosi, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_rx",   bus.rx_data, 8'h00);
    rst = 1'b0;

    repeat (6) @(negedge clk_in);
    chk("idle_cs_n", bus.cs_n, 1'b1);
    chk("idle_busy", bus.busy, 1'b0);

    // loopback timing transfer
    pulse_xfer(8'hA5, 100);
    chk("t1_cs_first",   cs_first, 1);
    chk("t1_first_rise", first_rise, 6);
    chk("t1_rises",      rises, 8);
    chk("t1_mosi_seq",   mosi_seq, 8'hA5);
    chk("t1_rx",         bus.rx_data, 8'hA5);
    chk("t1_done_at",    done_at0, 91);
    chk("t1_done_cnt",   done_cnt, 1);
    chk("t1_busy_fall",  busy_fall, 96);
    chk("t1_cs_last",    cs_last, 90);

    // miso tied high, all-zero word out
    loop_en = 1'b0; miso_val = 1'b1;
    pulse_xfer(8'h00, 100);
    chk("t2_rx",        bus.rx_data, 8'hFF);
    chk("t2_mosi_ones", mosi_ones, 0);
    chk("t2_cs_first",  cs_first, 1);
    chk("t2_cs_last",   cs_last, 90);
    chk("t2_done_at",   done_at0, 91);

    // start while busy is dropped
    loop_en = 1'b1;
    clear_obs();
    bus.start = 1'b1; bus.tx_data = 8'h5A;
    step();
    bus.start = 1'b0;
    repeat (38) step();
    bus.start = 1'b1; bus.tx_data = 8'h3C;
    step();
    bus.start = 1'b0;
    repeat (70) step();
    chk("t3_mosi_seq", mosi_seq, 8'h5A);
    chk("t3_rises",    rises, 8);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_rx",       bus.rx_data, 8'h5A);
    chk("t3_busy",     bus.busy, 1'b0);

    // start held high: back-to-back transfers
    clear_obs();
    bus.start = 1'b1; bus.tx_data = 8'h81;
    step();
    bus.tx_data = 8'h7E;
    repeat (99) step();
    bus.start = 1'b0;
    chk("t4_rx_first", bus.rx_data, 8'h81);
    repeat (100) step();
    chk("t4_done_cnt", done_cnt, 2);
    chk("t4_done_at0", done_at0, 91);
    chk("t4_done_gap", done_at1 - done_at0, 95);
    chk("t4_cs_gap",   gap, 5);
    chk("t4_rises",    rises, 16);
    chk("t4_rx",       bus.rx_data, 8'h7E);

    // asynchronous reset in the middle of a transfer
    clear_obs();
    bus.start = 1'b1; bus.tx_data = 8'hC3;
    step();
    bus.start = 1'b0;
    repeat (49) step();
    chk("t5_sclk_pre", bus.sclk, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_sclk", bus.sclk, 1'b0);
    chk("t5_cs_n", bus.cs_n, 1'b1);
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_done", bus.done, 1'b0);
    chk("t5_rx",   bus.rx_data, 8'h00);
    @(negedge clk_in);
    rst = 1'b0;
    clear_obs();
    repeat (20) step();
    chk("t5_no_done", done_cnt, 0);
    chk("t5_idle_cs", bus.cs_n, 1'b1);

    pulse_xfer(8'h96, 100);
    chk("t6_rx",       bus.rx_data, 8'h96);
    chk("t6_done_at",  done_at0, 91);
    chk("t6_busy_fall", busy_fall, 96);
    chk("t6_rises",    rises, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
